// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC prefix, LSB-first serializer,
// bit stuffing, NRZI and EOP, fed by a valid/ready one-byte holding buffer.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STUFF   = 3'd3;
    localparam logic [2:0] S_EOP_SE0 = 3'd4;
    localparam logic [2:0] S_EOP_J   = 3'd5;

    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state, nxt_state;
    logic [2:0] bit_idx, nxt_idx, idx_inc;
    logic [2:0] ones_cnt;
    logic [7:0] bit_cnt;
    logic [7:0] cur_data, hold_data;
    logic       cur_last, hold_last, hold_full;
    logic       level, nxt_level;
    logic       tick, hs, emit, emit_bit;
    logic       load_first, load_hold, underrun_set;

    assign tx_ready = !hold_full && (state != S_EOP_SE0) && (state != S_EOP_J);
    assign tx_busy  = (state != S_IDLE);
    assign hs       = tx_valid && tx_ready;
    assign tick     = (bit_cnt == BIT_LAST);
    assign idx_inc  = bit_idx + 3'd1;

    // The first byte moves to the shifter as SYNC starts, freeing the buffer
    // for the second byte a full SYNC time ahead of need.
    assign load_first = (state == S_SYNC) && (bit_idx == 3'd0) && (bit_cnt == 8'd0);
    assign nxt_level  = emit_bit ? level : !level;

    always_comb begin
        nxt_state    = state;
        nxt_idx      = bit_idx;
        emit         = 1'b0;
        emit_bit     = 1'b0;
        load_hold    = 1'b0;
        underrun_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    nxt_state = S_SYNC;
                    nxt_idx   = 3'd0;
                    emit      = 1'b1;
                end
            end
            S_SYNC: begin
                if (tick) begin
                    emit = 1'b1;
                    if (bit_idx != 3'd7) begin
                        nxt_idx  = idx_inc;
                        emit_bit = (idx_inc == 3'd7);
                    end else begin
                        nxt_state = S_DATA;
                        nxt_idx   = 3'd0;
                        emit_bit  = cur_data[0];
                    end
                end
            end
            S_DATA, S_STUFF: begin
                if (tick) begin
                    if (state == S_DATA && ones_cnt == 3'd6) begin
                        nxt_state = S_STUFF;
                        emit      = 1'b1;
                    end else if (bit_idx != 3'd7) begin
                        nxt_state = S_DATA;
                        nxt_idx   = idx_inc;
                        emit      = 1'b1;
                        emit_bit  = cur_data[idx_inc];
                    end else if (hold_full) begin
                        nxt_state = S_DATA;
                        nxt_idx   = 3'd0;
                        emit      = 1'b1;
                        emit_bit  = hold_data[0];
                        load_hold = 1'b1;
                    end else begin
                        nxt_state    = S_EOP_SE0;
                        nxt_idx      = 3'd0;
                        underrun_set = !cur_last;
                    end
                end
            end
            S_EOP_SE0: begin
                if (tick) begin
                    if (bit_idx == 3'd1) nxt_state = S_EOP_J;
                    else                 nxt_idx   = 3'd1;
                end
            end
            S_EOP_J: begin
                if (tick) begin
                    nxt_state = S_IDLE;
                    nxt_idx   = 3'd0;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_idx   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            bit_idx     <= 3'd0;
            bit_cnt     <= 8'd0;
            ones_cnt    <= 3'd0;
            level       <= 1'b1;
            d_plus      <= 1'b1;
            d_minus     <= 1'b0;
            tx_underrun <= 1'b0;
            hold_full   <= 1'b0;
            hold_data   <= 8'd0;
            hold_last   <= 1'b0;
            cur_data    <= 8'd0;
            cur_last    <= 1'b0;
        end else begin
            state       <= nxt_state;
            bit_idx     <= nxt_idx;
            tx_underrun <= underrun_set;
            bit_cnt     <= (state == S_IDLE || tick) ? 8'd0 : bit_cnt + 8'd1;

            if (hs) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
                hold_last <= tx_last;
            end else if (load_first || load_hold) begin
                hold_full <= 1'b0;
            end
            if (load_first || load_hold) begin
                cur_data <= hold_data;
                cur_last <= hold_last;
            end

            // Stuff bits go through emit as a 0, so they toggle and clear the run.
            if (emit) begin
                level    <= nxt_level;
                d_plus   <= nxt_level;
                d_minus  <= !nxt_level;
                ones_cnt <= emit_bit ? ones_cnt + 3'd1 : 3'd0;
            end else if (nxt_state == S_EOP_SE0 && state != S_EOP_SE0) begin
                d_plus  <= 1'b0;
                d_minus <= 1'b0;
            end else if (nxt_state == S_EOP_J && state == S_EOP_SE0) begin
                level   <= 1'b1;
                d_plus  <= 1'b1;
                d_minus <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: spec vectors, hand-written reset sequences and
// random packets, all checked against a bit-stream model of the USB line.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, d_plus, d_minus, tx_busy, tx_underrun;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready), .d_plus(d_plus),
        .d_minus(d_minus), .tx_busy(tx_busy), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [1:0] line_q[$];
    logic [1:0] exp_q[$];
    int busy_cnt = 0;
    int und_cnt = 0;

    typedef struct {
        int          n;
        logic [31:0] data;
        bit          last;
        int          busy;
        int          und;
    } vec_t;
    vec_t vecs[4];

    always @(negedge clk) begin
        if (tx_busy) begin
            line_q.push_back({d_plus, d_minus});
            busy_cnt++;
        end
        if (tx_underrun) und_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Line encoding {d_plus,d_minus}: J=2'b10, K=2'b01, SE0=2'b00.
    task automatic build_model(input int n, input logic [31:0] data);
        bit raw[$];
        bit stuffed[$];
        int ones;
        bit lvl;
        logic [31:0] d;
        d = data;
        for (int j = 0; j < 8; j++) raw.push_back(j == 7);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) raw.push_back(d[8*i+j]);
        ones = 0;
        foreach (raw[k]) begin
            stuffed.push_back(raw[k]);
            ones = raw[k] ? ones + 1 : 0;
            if (ones == 6) begin
                stuffed.push_back(1'b0);
                ones = 0;
            end
        end
        exp_q.delete();
        lvl = 1'b1;
        foreach (stuffed[k]) begin
            if (!stuffed[k]) lvl = !lvl;
            repeat (CPB) exp_q.push_back({lvl, !lvl});
        end
        repeat (2*CPB) exp_q.push_back(2'b00);
        repeat (CPB) exp_q.push_back(2'b10);
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic push(input logic [7:0] d, input bit l, input bit first);
        int k;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        k = 0;
        while (!tx_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_wait: got timeout expected tx_ready");
        end
        @(negedge clk);
        chk("ready_low_after_accept", int'(tx_ready), 0);
        if (first) begin
            chk("busy_at_t_plus_1", int'(tx_busy), 1);
            chk("first_sync_bit_K", int'({d_plus, d_minus}), 1);
        end
    endtask

    task automatic run_pkt(input string tag, input int n, input logic [31:0] data,
                           input bit last, input int maxd, input int exp_busy,
                           input int exp_und);
        int k;
        int bad;
        int dly;
        logic [31:0] d;
        d = data;
        line_q.delete();
        busy_cnt = 0;
        und_cnt  = 0;
        build_model(n, data);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && maxd > 0) begin
                dly = int'($urandom_range(maxd, 0));
                if (dly > 0) begin
                    tx_valid = 1'b0;
                    repeat (dly) @(negedge clk);
                end
            end
            push(d[8*i+:8], last && (i == n-1), i == 0);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        k = 0;
        while (tx_busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_end_in_bound"}, int'(tx_busy), 0);
        if (exp_busy >= 0) chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_busy_vs_model"}, busy_cnt, exp_q.size());
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= line_q.size() || line_q[i] != exp_q[i]) begin
                bad = i;
                break;
            end
        if (bad < 0 && line_q.size() != exp_q.size()) bad = exp_q.size();
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_lines: first differing cycle %0d, got %0d samples expected %0d",
                     tag, bad, line_q.size(), exp_q.size());
        end
        chk({tag, "_underrun_pulses"}, und_cnt, exp_und);
        chk({tag, "_idle_line_J"}, int'({d_plus, d_minus}), 2);
        chk({tag, "_ready_after_eop"}, int'(tx_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 32'h0000_0000, 1'b1, 152, 0};
        vecs[1] = '{1, 32'h0000_00FF, 1'b1, 160, 0};
        vecs[2] = '{2, 32'h0000_3CA5, 1'b1, 216, 0};
        vecs[3] = '{1, 32'h0000_0001, 1'b0, 152, 1};

        repeat (3) @(negedge clk);
        chk("rst_d_plus", int'(d_plus), 1);
        chk("rst_d_minus", int'(d_minus), 0);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_underrun", int'(tx_underrun), 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++)
            run_pkt($sformatf("vec%0d", v), vecs[v].n, vecs[v].data, vecs[v].last,
                    0, vecs[v].busy, vecs[v].und);

        // Reset in the middle of the DATA bits of a two-byte packet.
        repeat (3) @(negedge clk);
        push(8'hFF, 1'b0, 1'b1);
        push(8'h00, 1'b1, 1'b0);
        tx_valid = 1'b0;
        repeat (80) @(negedge clk);
        chk("midpkt_busy_before_rst", int'(tx_busy), 1);
        n_rst = 1'b0;
        #1;
        chk("midpkt_rst_d_plus", int'(d_plus), 1);
        chk("midpkt_rst_d_minus", int'(d_minus), 0);
        chk("midpkt_rst_busy", int'(tx_busy), 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", int'(tx_ready), 1);
        run_pkt("post_rst", 1, 32'h0000_00FF, 1'b1, 0, 160, 0);

        for (int r = 0; r < 12; r++) begin
            int n;
            bit last;
            n    = int'($urandom_range(4, 1));
            last = ($urandom_range(3, 0) != 0);
            run_pkt($sformatf("rnd%0d", r), n, $urandom, last,
                    int'($urandom_range(20, 0)), -1, last ? 0 : 1);
            repeat (int'($urandom_range(5, 0))) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Transmit-side USB full-speed line encoder: the counterpart of the receive path's edge detection and NRZI decode. It accepts packet bytes from the upstream packet builder through a valid/ready handshake with a one-byte holding buffer. It automatically prefixes SYNC, serializes bytes LSB first, applies bit stuffing and NRZI encoding, and terminates with EOP. Its outputs drive the d_plus/d_minus pad drivers.

## Interface
- CLKS_PER_BIT, default 8: clock cycles per USB bit time; allowed range 2 to 255.
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- tx_data  input  8  packet byte.
- tx_valid  input  1  tx_data and tx_last are valid.
- tx_last  input  1  this byte is the final byte of the packet.
- tx_ready  output  1  the holding buffer can accept a byte; a byte transfers on a cycle where tx_valid and tx_ready are both 1.
- d_plus  output  1  registered D+ line level.
- d_minus  output  1  registered D- line level.
- tx_busy  output  1  a packet is on the line, from the first SYNC bit through the end of the EOP J bit.
- tx_underrun  output  1  one-cycle pulse when the packet is aborted because the buffer was empty.

## Operation
- Line states:
  - J: d_plus=1, d_minus=0.
  - K: d_plus=0, d_minus=1.
  - SE0: both 0.
  - Idle line is J.
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- Holding buffer: one entry storing {tx_last, tx_data}.
  - tx_ready = buffer empty AND state is not EOP_SE0 or EOP_J.
  - The buffer empties when the shifter loads from it.
- IDLE: a handshake writes the buffer, and the next cycle enters SYNC.
- SYNC: sends the bit sequence 0,0,0,0,0,0,0,1 (the 0x80 pattern, LSB first).
- Byte boundary: at the end of the last bit of SYNC, or of the current byte (including any stuff bit that follows bit 7):
  - Buffer full: load the shifter, clear the buffer, continue in DATA.
  - Buffer empty and the byte just sent had tx_last=1: go to EOP_SE0.
  - Buffer empty and tx_last was not set: underrun. Pulse tx_underrun for one cycle, on the first EOP_SE0 cycle, and go to EOP_SE0.
- NRZI: a 0 bit toggles J and K; a 1 bit holds the previous level. The NRZI level starts at J for each packet.
- Bit stuffing:
  - A ones counter (3 bits) counts consecutive 1 bits, including the final 1 of SYNC.
  - When the count reaches 6, the next bit time is STUFF: a 0 bit (toggle), which does not consume a data bit. The counter then clears.
  - Any 0 bit clears the counter. A stuff is required even when the sixth 1 is bit 7 of the last byte.
- EOP: EOP_SE0 holds SE0 for 2 bit times, then EOP_J holds J for 1 bit time, then IDLE.
- tx_last of the buffered byte is captured with its data. Handshakes that complete during EOP are impossible, because tx_ready=0 there.

## Timing
- Reset: async clear.
  - State IDLE, buffer empty, counters 0.
  - d_plus=1, d_minus=0, tx_busy=0, tx_underrun=0, tx_ready=1 (combinational from IDLE with an empty buffer).
- Bit timer: counts 0 to CLKS_PER_BIT-1. Line outputs update only on the first cycle of each bit time.
- Latency: the handshake in IDLE happens at cycle t. The first SYNC bit (K) and tx_busy=1 appear at t+1.
- Throughput: after the first byte loads into the shifter at SYNC start, tx_ready=1 from the next cycle. Upstream has a full byte time to supply the next byte; a byte supplied in time produces no gap.
- tx_busy falls on the cycle after the last EOP_J cycle. The line is then J. tx_ready is 1 again on that same cycle.
- Packet length in cycles: CLKS_PER_BIT × (8 + 8·N + stuff bits + 3), where N is the number of bytes.
- Reset mid-packet: the line returns to J immediately, with no EOP. Any buffered byte is discarded.

## Test plan
- Reset with CLKS_PER_BIT=8 -> d_plus=1, d_minus=0, tx_busy=0, tx_ready=1, tx_underrun=0.
- Single byte 0x00, tx_last=1 -> per-bit line sequence:
  - SYNC: K J K J K J K K.
  - Data: J K J K J K J K.
  - EOP: SE0 for 16 cycles, then J for 8 cycles.
  - tx_busy is high for 152 cycles.
- Single byte 0xFF, tx_last=1:
  - SYNC as above.
  - Data: K ×5, then a stuff J, then J ×3.
  - tx_busy is high for 160 cycles.
- Back-to-back 0xA5 then 0x3C (last=1), tx_valid held:
  - tx_ready falls after each accept.
  - No gap between bytes; no stuff bits.
  - tx_busy is high for 216 cycles.
- 0x01 with tx_last=0, then tx_valid low -> after the byte's 8 bits:
  - tx_underrun pulses for 1 cycle.
  - SE0 for 16 cycles, J for 8 cycles.
  - tx_busy is high for 152 cycles.
- n_rst asserted during the DATA bits of a 2-byte packet -> d_plus=1 and d_minus=0 immediately, tx_busy=0. A new packet afterwards starts with a clean SYNC, and the ones counter starts from 0.
